// File: rtl/adder_cla_seq.sv
// Wide add/subtract built by time-multiplexing one NBIT carry-lookahead adder.
// Words are processed LSW first, one per clock, with the carry held in a register.
module adder_cla #(
  parameter int NBIT = 32
) (
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            ci,
  output logic [NBIT-1:0] s,
  output logic            co
);
  logic [NBIT-1:0] g, p;
  logic [NBIT:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = ci;
    for (int i = 0; i < NBIT; i++)
      c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[NBIT-1:0];
  assign co = c[NBIT];
endmodule

module adder_cla_seq #(
  parameter int NBIT  = 32,
  parameter int NWORD = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NBIT*NWORD-1:0] i_a,
  input  logic [NBIT*NWORD-1:0] i_b,
  input  logic                  i_c,
  input  logic                  i_sub,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NBIT*NWORD-1:0] o_s,
  output logic                  o_c,
  output logic                  o_busy
);
  localparam int IW = $clog2(NWORD);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]                idx;
  logic                         cy;
  logic                         sub_r;
  logic [NWORD-1:0][NBIT-1:0]   a_w, b_w, s_w;
  logic [NBIT-1:0]              add_b, add_s;
  logic                         add_co;
  logic                         accept, last;

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state == CALC) || (state == DONE);
  assign accept  = i_valid && o_ready;
  assign last    = (idx == IW'(NWORD-1));
  assign o_s     = s_w;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)  state_nxt = CALC;
      CALC:    if (last)    state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: the +1 enters as the initial carry.
  assign add_b = sub_r ? ~b_w[idx] : b_w[idx];

  adder_cla #(.NBIT(NBIT)) u_add (
    .a  (a_w[idx]),
    .b  (add_b),
    .ci (cy),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_w   <= '0;
      b_w   <= '0;
      s_w   <= '0;
      sub_r <= 1'b0;
      idx   <= '0;
      cy    <= 1'b0;
      o_c   <= 1'b0;
    end else if (accept) begin
      a_w   <= i_a;
      b_w   <= i_b;
      sub_r <= i_sub;
      idx   <= '0;
      cy    <= i_sub | i_c;
    end else if (state == CALC) begin
      s_w[idx] <= add_s;
      cy       <= add_co;
      if (last) o_c <= add_co;
      else      idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_adder_cla_seq.sv
// Scoreboard bench for adder_cla_seq at NBIT=32, NWORD=4.
// Expected results are queued at acceptance and compared at the output handshake.
module tb_adder_cla_seq;
  localparam int NBIT  = 32;
  localparam int NWORD = 4;
  localparam int W     = NBIT*NWORD;

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_c, i_sub, i_ready;
  logic [W-1:0] i_a, i_b;
  logic         o_ready, o_valid, o_c, o_busy;
  logic [W-1:0] o_s;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W:0] sb[$];
  int         acc_q[$];

  adder_cla_seq #(.NBIT(NBIT), .NWORD(NWORD)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_s     (o_s),
    .o_c     (o_c),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic expect_eq(input string tag,
                           input logic [131:0] got,
                           input logic [131:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic c,
                                       input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    else     return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  always @(negedge i_clk) begin : mon
    logic [W:0] e;
    if (!i_rst && i_valid && o_ready) begin
      sb.push_back(model(i_a, i_b, i_c, i_sub));
      acc_q.push_back(cyc);
    end
    if (!i_rst && o_valid && i_ready) begin
      if (sb.size() == 0) expect_eq("sb_underflow", 0, 1);
      else begin
        e = sb.pop_front();
        expect_eq("sb_result", {o_c, o_s}, e);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic sub);
    int  t;
    logic ok;
    i_a = a; i_b = b; i_c = c; i_sub = sub; i_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge i_clk);
      ok = o_ready;
      tick();
      if (ok) break;
      t++;
      if (t > 40) begin
        expect_eq("req_timeout", 0, 1);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_res();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic op(input string tag,
                    input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c, input logic sub,
                    input logic [W:0] exp);
    int lat;
    req(a, b, c, sub);
    wait_valid(lat);
    expect_eq({tag, "_lat"}, lat, NWORD);
    expect_eq(tag, {o_c, o_s}, exp);
    release_res();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] ra, rb, hs;
    logic         hc;
    int           lat, t;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_c = 1'b0; i_sub = 1'b0;
    repeat (2) tick();
    expect_eq("rst_state", {o_ready, o_valid, o_busy, o_c, o_s},
              {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    i_rst = 1'b0;
    tick();

    op("add_ripple", {W{1'b1}}, 128'd1, 1'b0, 1'b0, {1'b1, {W{1'b0}}});
    op("sub_5_3", 128'd5, 128'd3, 1'b1, 1'b1, {1'b1, 128'd2});
    op("sub_3_5", 128'd3, 128'd5, 1'b1, 1'b1,
       {1'b0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE});
    op("add_cin", 128'd0, 128'd0, 1'b1, 1'b0, {1'b0, 128'd1});
    op("add_mid", 128'h00000000_FFFFFFFF_00000000_FFFFFFFF, 128'd1,
       1'b0, 1'b0, {1'b0, 128'h00000000_FFFFFFFF_00000001_00000000});

    for (int k = 0; k < 4; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      req(ra, rb, k[0], k[1]);
      wait_valid(lat);
      expect_eq("rand_lat", lat, NWORD);
      release_res();
    end

    // Result held while consumer stalls; new requests ignored.
    req(128'd1000, 128'd1, 1'b0, 1'b1);
    wait_valid(lat);
    hs = o_s; hc = o_c;
    expect_eq("hold_val", {o_c, o_s}, {1'b1, 128'd999});
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_a = {$urandom, $urandom, $urandom, $urandom};
      i_b = {$urandom, $urandom, $urandom, $urandom};
      tick();
      expect_eq("hold", {o_valid, o_ready, o_c, o_s},
                {1'b1, 1'b0, hc, hs});
    end
    i_a = 128'd100; i_b = 128'd23; i_c = 1'b0; i_sub = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    expect_eq("hold_idle", {o_ready, o_valid}, 2'b10);
    tick();
    i_valid = 1'b0;
    expect_eq("hold_accept", {o_busy, o_ready}, 2'b10);
    wait_valid(lat);
    expect_eq("hold_next", {o_c, o_s}, {1'b0, 128'd123});
    release_res();

    // Abort mid-operation with an asynchronous reset.
    req(128'd55, 128'd66, 1'b0, 1'b0);
    tick();
    tick();
    #2 i_rst = 1'b1;
    #1;
    expect_eq("abort_rst", {o_ready, o_valid, o_busy, o_c, o_s},
              {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    sb.delete();
    i_valid = 1'b1; i_a = 128'd1; i_b = 128'd2;
    tick();
    tick();
    i_valid = 1'b0;
    i_rst = 1'b0;
    tick();
    expect_eq("rst_no_accept", {o_busy, o_ready}, 2'b01);
    op("post_rst", 128'd7, 128'd9, 1'b0, 1'b0, {1'b0, 128'd16});

    // Back-to-back requests with both handshakes held high.
    acc_q.delete();
    i_ready = 1'b1;
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_a = {$urandom, $urandom, $urandom, $urandom};
      i_b = {$urandom, $urandom, $urandom, $urandom};
      i_c = k[0]; i_sub = (k == 1);
      t = 0;
      while (acc_q.size() <= k && t < 40) begin
        tick();
        t++;
      end
      if (t >= 40) expect_eq("b2b_timeout", 0, 1);
    end
    i_valid = 1'b0;
    t = 0;
    while (sb.size() > 0 && t < 60) begin
      tick();
      t++;
    end
    tick();
    i_ready = 1'b0;
    expect_eq("b2b_drain", sb.size(), 0);
    if (acc_q.size() == 3) begin
      expect_eq("b2b_gap1", acc_q[1] - acc_q[0], NWORD + 2);
      expect_eq("b2b_gap2", acc_q[2] - acc_q[1], NWORD + 2);
    end else begin
      expect_eq("b2b_accepts", acc_q.size(), 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
